// File: rtl/nrs_gold_seq_gen_if.sv
// nrs_gold_seq_gen_if: control, c_init/pair-count load and bit-pair stream handshake of the NRS Gold generator
interface nrs_gold_seq_gen_if #(
    parameter int LEN_W = 8
);
    logic [30:0]      cinit;
    logic             start;
    logic [LEN_W-1:0] num_pairs;
    logic [1:0]       c_pair;
    logic             c_valid;
    logic             c_ready;
    logic             busy;
    logic             done;

    modport master (
        output cinit, start, num_pairs, c_ready,
        input  c_pair, c_valid, busy, done
    );

    modport slave (
        input  cinit, start, num_pairs, c_ready,
        output c_pair, c_valid, busy, done
    );
endinterface

// File: rtl/nrs_gold_seq_gen.sv
// nrs_gold_seq_gen: length-31 Gold sequence generator (NB-IoT NRS), two LFSR steps per clock; NRS_GOLD_RESTART_EN lets start abort a running sequence
module nrs_gold_seq_gen #(
    parameter int NC    = 1600,
    parameter int LEN_W = 8
) (
    input logic               clk,
    input logic               rst,
    nrs_gold_seq_gen_if.slave bus
);
    localparam int CW = (NC / 2 > 1) ? $clog2(NC / 2) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WARM = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [30:0]      x1_q, x1_d, x2_q, x2_d;
    logic [30:0]      x1_adv, x2_adv;
    logic [CW-1:0]    warm_q, warm_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             load;

`ifdef NRS_GOLD_RESTART_EN
    assign load = bus.start;
`else
    assign load = bus.start && state_q == S_IDLE;
`endif

    // two recurrence steps at once; bit 0 holds the oldest element, new elements enter at the top
    always_comb begin
        x1_adv = {x1_q[4] ^ x1_q[1], x1_q[3] ^ x1_q[0], x1_q[30:2]};
        x2_adv = {^x2_q[4:1], ^x2_q[3:0], x2_q[30:2]};
    end

    // next-state: warm-up advances every cycle, output advances only on handshake; a load overrides everything
    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        warm_d  = warm_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_WARM: begin
                x1_d   = x1_adv;
                x2_d   = x2_adv;
                warm_d = (warm_q == '0) ? warm_q : warm_q - 1'b1;
                if (warm_q == '0) begin
                    state_d = (rem_q == '0) ? S_IDLE : S_OUT;
                    done_d  = (rem_q == '0);
                end
            end
            S_OUT: begin
                if (bus.c_ready) begin
                    x1_d  = x1_adv;
                    x2_d  = x2_adv;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d = S_WARM;
            x1_d    = 31'h0000_0001;
            x2_d    = bus.cinit;
            rem_d   = bus.num_pairs;
            warm_d  = CW'(NC / 2 - 1);
            done_d  = 1'b0;
        end
    end

    // state registers; reset discards any partial sequence without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x1_q    <= '0;
            x2_q    <= '0;
            warm_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            warm_q  <= warm_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign bus.c_valid = (state_q == S_OUT);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.c_pair  = (state_q == S_OUT) ? {x1_q[1] ^ x2_q[1], x1_q[0] ^ x2_q[0]} : 2'b00;
endmodule
